// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer (BOOT -> FETCH <-> HOLD).
// Optional misaligned-PC trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned COUNT_W  = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [31:0]        PCNext,
   output logic [31:0]        PC,
   output logic [31:0]        addPC,
   output logic               imemReq,
   output logic [31:0]        imemAddr,
   input  logic               imemReady,
   input  logic [31:0]        imemData,
   output logic [31:0]        instruction,
   output logic               instrValid,
   input  logic               instrReady,
   output logic [COUNT_W-1:0] instrCount,
   output logic               pcMisaligned
);

`ifdef PC_ALIGN_CHECK_EN
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, FAULT} state_t;
`else
   typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

   state_t state;

   assign addPC    = PC + 32'd4;
   assign imemReq  = (state == FETCH);
   assign imemAddr = PC;

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pcMisaligned <= 1'b0;
      end else if (state == HOLD && instrReady && PCNext[1:0] != 2'b00) begin
         pcMisaligned <= 1'b1;
      end
   end
`else
   assign pcMisaligned = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= BOOT;
         PC          <= RESET_PC;
         instruction <= '0;
         instrValid  <= 1'b0;
         instrCount  <= '0;
      end else begin
         case (state)
            BOOT: state <= FETCH;
            FETCH: begin
               if (imemReady) begin
                  instruction <= imemData;
                  instrValid  <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (instrReady) begin
                  instrValid <= 1'b0;
                  instrCount <= instrCount + COUNT_W'(1);
`ifdef PC_ALIGN_CHECK_EN
                  // A misaligned target still retires the current instruction but parks the fetcher.
                  if (PCNext[1:0] != 2'b00) begin
                     state <= FAULT;
                  end else begin
                     PC    <= PCNext;
                     state <= FETCH;
                  end
`else
                  PC    <= PCNext;
                  state <= FETCH;
`endif
               end
            end
`ifdef PC_ALIGN_CHECK_EN
            FAULT: state <= FAULT;
`endif
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; expectations follow PC_ALIGN_CHECK_EN if defined.
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] PCNext;
   logic [31:0] PC;
   logic [31:0] addPC;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady;
   logic [31:0] imemData;
   logic [31:0] instruction;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instrCount;
   logic        pcMisaligned;

   int checks = 0;
   int errors = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
      .clock(clock), .reset_n(reset_n), .PCNext(PCNext), .PC(PC), .addPC(addPC),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
      .instruction(instruction), .instrValid(instrValid), .instrReady(instrReady),
      .instrCount(instrCount), .pcMisaligned(pcMisaligned)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      PCNext     = 32'hxxxx_xxxx;
      imemReady  = 1'b0;
      imemData   = 32'h0;
      instrReady = 1'b0;
      #12;
      check("rst_pc", PC, 32'h0);
      check("rst_req", {31'b0, imemReq}, 32'h0);
      check("rst_valid", {31'b0, instrValid}, 32'h0);
      check("rst_instr", instruction, 32'h0);
      check("rst_count", instrCount, 32'h0);
      check("rst_mis", {31'b0, pcMisaligned}, 32'h0);

      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("boot_req", {31'b0, imemReq}, 32'h0);
      step();
      check("fetch_req", {31'b0, imemReq}, 32'h1);
      check("fetch_addr", imemAddr, 32'h0);
      check("fetch_addpc", addPC, 32'h4);

      imemReady = 1'b1;
      imemData  = 32'h0050_0093;
      step();
      check("hold_instr", instruction, 32'h0050_0093);
      check("hold_valid", {31'b0, instrValid}, 32'h1);
      check("hold_req", {31'b0, imemReq}, 32'h0);

      // Stray memory response during the stall must not disturb the held word.
      imemData = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_instr", instruction, 32'h0050_0093);
         check("stall_valid", {31'b0, instrValid}, 32'h1);
         check("stall_pc", PC, 32'h0);
      end
      imemReady  = 1'b0;
      PCNext     = 32'h4;
      instrReady = 1'b1;
      step();
      check("seq_pc", PC, 32'h4);
      check("seq_count", instrCount, 32'h1);
      check("seq_req", {31'b0, imemReq}, 32'h1);
      check("seq_valid", {31'b0, instrValid}, 32'h0);
      instrReady = 1'b0;
      PCNext     = 32'hxxxx_xxxx;

      imemReady = 1'b1;
      imemData  = 32'h0010_0113;
      step();
      check("hold2_instr", instruction, 32'h0010_0113);
      imemReady  = 1'b0;
      PCNext     = 32'h0000_0040;
      instrReady = 1'b1;
      step();
      check("br_pc", PC, 32'h40);
      check("br_addr", imemAddr, 32'h40);
      check("br_count", instrCount, 32'h2);
      instrReady = 1'b0;
      PCNext     = 32'hxxxx_xxxx;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_req", {31'b0, imemReq}, 32'h1);
         check("wait_addr", imemAddr, 32'h40);
      end

      reset_n   = 1'b0;
      imemReady = 1'b1;
      imemData  = 32'h1234_5678;
      #1;
      check("mrst_req", {31'b0, imemReq}, 32'h0);
      check("mrst_pc", PC, 32'h0);
      check("mrst_count", instrCount, 32'h0);
      check("mrst_valid", {31'b0, instrValid}, 32'h0);
      step();
      check("mrst_instr", instruction, 32'h0);
      check("mrst_valid2", {31'b0, instrValid}, 32'h0);
      reset_n = 1'b1;
      step();
      check("rec_valid", {31'b0, instrValid}, 32'h0);
      check("rec_req", {31'b0, imemReq}, 32'h1);
      imemData = 32'h0000_0013;
      step();
      check("rec_instr", instruction, 32'h0000_0013);
      check("rec_hvalid", {31'b0, instrValid}, 32'h1);
      imemReady = 1'b0;

      PCNext     = 32'hFFFF_FFFC;
      instrReady = 1'b1;
      step();
      check("top_pc", PC, 32'hFFFF_FFFC);
      check("wrap_addpc", addPC, 32'h0);
      check("top_count", instrCount, 32'h1);
      instrReady = 1'b0;
      imemReady  = 1'b1;
      imemData   = 32'h0000_0033;
      step();
      check("top_instr", instruction, 32'h0000_0033);
      imemReady = 1'b0;

      PCNext     = 32'h0000_0042;
      instrReady = 1'b1;
      step();
      check("mis_count", instrCount, 32'h2);
`ifdef PC_ALIGN_CHECK_EN
      check("mis_pc", PC, 32'hFFFF_FFFC);
      check("mis_flag", {31'b0, pcMisaligned}, 32'h1);
      imemReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("fault_req", {31'b0, imemReq}, 32'h0);
         check("fault_valid", {31'b0, instrValid}, 32'h0);
         check("fault_pc", PC, 32'hFFFF_FFFC);
      end
`else
      check("mis_pc", PC, 32'h42);
      check("mis_flag", {31'b0, pcMisaligned}, 32'h0);
      check("mis_req", {31'b0, imemReq}, 32'h1);
      check("mis_addpc", addPC, 32'h46);
`endif
      instrReady = 1'b0;
      imemReady  = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
